// File: rtl/wisc_pkg.sv
// rtl/wisc_pkg.sv - opcodes, ALU encodings and decoded control bundle shared by the WISC core.
package wisc_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_ADDZ = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_NOR  = 4'h4;
  localparam logic [3:0] OP_SLL  = 4'h5;
  localparam logic [3:0] OP_SRL  = 4'h6;
  localparam logic [3:0] OP_SRA  = 4'h7;
  localparam logic [3:0] OP_LW   = 4'h8;
  localparam logic [3:0] OP_SW   = 4'h9;
  localparam logic [3:0] OP_LHB  = 4'hA;
  localparam logic [3:0] OP_LLB  = 4'hB;
  localparam logic [3:0] OP_B    = 4'hC;
  localparam logic [3:0] OP_HLT  = 4'hF;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_NOR = 3'd3;
  localparam logic [2:0] ALU_SLL = 3'd4;
  localparam logic [2:0] ALU_SRL = 3'd5;
  localparam logic [2:0] ALU_SRA = 3'd6;
  localparam logic [2:0] ALU_LHB = 3'd7;

  // imm8 is the raw signed immediate; the stage widens it to the datapath width.
  typedef struct packed {
    logic [3:0] p0_addr;
    logic [3:0] p1_addr;
    logic [3:0] dst_addr;
    logic       re0;
    logic       re1;
    logic       we;
    logic       we_zr;
    logic       mem_rd;
    logic       mem_wr;
    logic [2:0] alu_op;
    logic       src1sel;
    logic [3:0] shamt;
    logic [7:0] imm8;
    logic       branch;
    logic [2:0] br_cond;
    logic       hlt;
  } ctrl_t;

endpackage

// File: rtl/id_decode.sv
// rtl/id_decode.sv - combinational 16-bit instruction to control bundle decoder.
module id_decode
  import wisc_pkg::*;
(
  input  logic [15:0] instr,
  output ctrl_t       ctrl
);

  logic [3:0] op;
  logic [3:0] rd;
  logic [3:0] rs;
  logic [3:0] rt;

  assign op = instr[15:12];
  assign rd = instr[11:8];
  assign rs = instr[7:4];
  assign rt = instr[3:0];

  always_comb begin
    ctrl          = '0;
    ctrl.p0_addr  = rs;
    ctrl.p1_addr  = rt;
    ctrl.dst_addr = rd;
    ctrl.src1sel  = 1'b1;
    ctrl.alu_op   = ALU_ADD;
    ctrl.br_cond  = instr[11:9];
    case (op)
      OP_ADD, OP_ADDZ, OP_SUB, OP_AND, OP_NOR: begin
        ctrl.re0   = 1'b1;
        ctrl.re1   = 1'b1;
        ctrl.we    = 1'b1;
        ctrl.we_zr = (op == OP_ADDZ);
        case (op)
          OP_SUB:  ctrl.alu_op = ALU_SUB;
          OP_AND:  ctrl.alu_op = ALU_AND;
          OP_NOR:  ctrl.alu_op = ALU_NOR;
          default: ctrl.alu_op = ALU_ADD;
        endcase
      end
      OP_SLL, OP_SRL, OP_SRA: begin
        ctrl.re0     = 1'b1;
        ctrl.we      = 1'b1;
        ctrl.src1sel = 1'b0;
        ctrl.shamt   = rt;
        case (op)
          OP_SLL:  ctrl.alu_op = ALU_SLL;
          OP_SRL:  ctrl.alu_op = ALU_SRL;
          default: ctrl.alu_op = ALU_SRA;
        endcase
      end
      OP_LW: begin
        ctrl.re0     = 1'b1;
        ctrl.we      = 1'b1;
        ctrl.mem_rd  = 1'b1;
        ctrl.src1sel = 1'b0;
        ctrl.imm8    = {{4{rt[3]}}, rt};
      end
      OP_SW: begin
        // Store data comes from rd, so it rides the second read port.
        ctrl.re0     = 1'b1;
        ctrl.re1     = 1'b1;
        ctrl.mem_wr  = 1'b1;
        ctrl.p1_addr = rd;
        ctrl.src1sel = 1'b0;
        ctrl.imm8    = {{4{rt[3]}}, rt};
      end
      OP_LHB: begin
        ctrl.re0     = 1'b1;
        ctrl.we      = 1'b1;
        ctrl.p0_addr = rd;
        ctrl.src1sel = 1'b0;
        ctrl.imm8    = instr[7:0];
        ctrl.alu_op  = ALU_LHB;
      end
      OP_LLB: begin
        ctrl.re0     = 1'b1;
        ctrl.we      = 1'b1;
        ctrl.p0_addr = 4'd0;
        ctrl.src1sel = 1'b0;
        ctrl.imm8    = instr[7:0];
      end
      OP_B:    ctrl.branch = 1'b1;
      OP_HLT:  ctrl.hlt    = 1'b1;
      default: ctrl.we     = 1'b0;
    endcase
  end

endmodule

// File: rtl/id_stage.sv
// rtl/id_stage.sv - registered decode stage with load-use stalling, flush and sticky halt.
module id_stage
  import wisc_pkg::*;
#(
  parameter int DW       = 16,
  parameter int PCW      = 16,
  parameter int LOAD_LAT = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [15:0]    in_instr,
  input  logic [PCW-1:0] in_pc,
  input  logic           flush,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [PCW-1:0] out_pc,
  output logic [3:0]     p0_addr,
  output logic [3:0]     p1_addr,
  output logic [3:0]     dst_addr,
  output logic           re0,
  output logic           re1,
  output logic           we,
  output logic           we_zr,
  output logic           mem_rd,
  output logic           mem_wr,
  output logic [2:0]     alu_op,
  output logic           src1sel,
  output logic [3:0]     shamt,
  output logic [DW-1:0]  imm,
  output logic           branch,
  output logic [2:0]     br_cond,
  output logic           hlt,
  output logic           stall,
  output logic           halted
);

  localparam logic [1:0] LAT = 2'(LOAD_LAT);

  ctrl_t          dec;
  ctrl_t          ctrl_q;
  logic [PCW-1:0] pc_q;
  logic           valid_q;
  logic           stall_q;
  logic           halted_q;
  logic [3:0]     ld_dst;
  logic [1:0]     ld_cnt;
  logic           hazard;
  logic           adv;
  logic           accept;

  id_decode u_decode (
    .instr(in_instr),
    .ctrl (dec)
  );

  assign hazard = in_valid && (ld_cnt != 2'd0) &&
                  ((dec.re0 && (dec.p0_addr == ld_dst)) ||
                   (dec.re1 && (dec.p1_addr == ld_dst)));
  assign adv    = !valid_q || out_ready;
  // Held low while in reset so fetch never sees a ready it cannot use.
  assign in_ready = rst_n && adv && !hazard && !halted_q && !flush;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q   <= '0;
      pc_q     <= '0;
      valid_q  <= 1'b0;
      stall_q  <= 1'b0;
      halted_q <= 1'b0;
      ld_dst   <= 4'd0;
      ld_cnt   <= 2'd0;
    end else if (flush) begin
      ctrl_q  <= '0;
      pc_q    <= '0;
      valid_q <= 1'b0;
      stall_q <= 1'b0;
      ld_cnt  <= 2'd0;
    end else begin
      if (accept) begin
        ctrl_q  <= dec;
        pc_q    <= in_pc;
        valid_q <= 1'b1;
        stall_q <= 1'b0;
        if (dec.hlt) halted_q <= 1'b1;
      end else if (adv) begin
        // Bundle consumed with nothing new: drop valid, mark a bubble if stalling.
        valid_q <= 1'b0;
        stall_q <= hazard;
        if (hazard) begin
          ctrl_q <= '0;
          pc_q   <= '0;
        end
      end
      if (accept && dec.mem_rd) begin
        ld_dst <= dec.dst_addr;
        ld_cnt <= LAT;
      end else if (out_ready && (ld_cnt != 2'd0)) begin
        ld_cnt <= ld_cnt - 2'd1;
      end
    end
  end

  assign out_valid = valid_q;
  assign out_pc    = pc_q;
  assign p0_addr   = ctrl_q.p0_addr;
  assign p1_addr   = ctrl_q.p1_addr;
  assign dst_addr  = ctrl_q.dst_addr;
  assign re0       = ctrl_q.re0;
  assign re1       = ctrl_q.re1;
  assign we        = ctrl_q.we;
  assign we_zr     = ctrl_q.we_zr;
  assign mem_rd    = ctrl_q.mem_rd;
  assign mem_wr    = ctrl_q.mem_wr;
  assign alu_op    = ctrl_q.alu_op;
  assign src1sel   = ctrl_q.src1sel;
  assign shamt     = ctrl_q.shamt;
  assign imm       = {{(DW-8){ctrl_q.imm8[7]}}, ctrl_q.imm8};
  assign branch    = ctrl_q.branch;
  assign br_cond   = ctrl_q.br_cond;
  assign hlt       = ctrl_q.hlt;
  assign stall     = stall_q;
  assign halted    = halted_q;

endmodule

// File: tb/tb_id_stage.sv
// tb/tb_id_stage.sv - scoreboard bench for id_stage with LOAD_LAT = 2.
module tb_id_stage;
  import wisc_pkg::*;

  typedef struct packed {
    logic [15:0] pc;
    logic [3:0]  p0;
    logic [3:0]  p1;
    logic [3:0]  dst;
    logic        re0;
    logic        re1;
    logic        we;
    logic        we_zr;
    logic        mem_rd;
    logic        mem_wr;
    logic [2:0]  alu;
    logic        src1sel;
    logic [3:0]  shamt;
    logic [15:0] imm;
    logic        branch;
    logic [2:0]  br_cond;
    logic        hlt;
  } bun_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_instr;
  logic [15:0] in_pc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_pc;
  logic [3:0]  p0_addr, p1_addr, dst_addr;
  logic        re0, re1, we, we_zr, mem_rd, mem_wr;
  logic [2:0]  alu_op;
  logic        src1sel;
  logic [3:0]  shamt;
  logic [15:0] imm;
  logic        branch;
  logic [2:0]  br_cond;
  logic        hlt, stall, halted;

  int   errors = 0;
  int   checks = 0;
  bun_t sb[$];
  bun_t e;
  bun_t g;

  always #5 clk = ~clk;

  id_stage #(.DW(16), .PCW(16), .LOAD_LAT(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc(out_pc), .p0_addr(p0_addr), .p1_addr(p1_addr),
    .dst_addr(dst_addr), .re0(re0), .re1(re1), .we(we), .we_zr(we_zr),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .alu_op(alu_op), .src1sel(src1sel),
    .shamt(shamt), .imm(imm), .branch(branch), .br_cond(br_cond), .hlt(hlt),
    .stall(stall), .halted(halted)
  );

  function automatic bun_t ref_decode(input logic [15:0] i, input logic [15:0] pc);
    bun_t       b;
    logic [3:0] op;
    op        = i[15:12];
    b         = '0;
    b.pc      = pc;
    b.dst     = i[11:8];
    b.p0      = (op == 4'hB) ? 4'd0 : (op == 4'hA) ? i[11:8] : i[7:4];
    b.p1      = (op == 4'h9) ? i[11:8] : i[3:0];
    b.re0     = !(op == 4'hF || op == 4'hC || op == 4'hD || op == 4'hE);
    b.re1     = (op <= 4'h4) || (op == 4'h9);
    b.we      = (op <= 4'h8) || (op == 4'hA) || (op == 4'hB);
    b.we_zr   = (op == 4'h1);
    b.mem_rd  = (op == 4'h8);
    b.mem_wr  = (op == 4'h9);
    case (op)
      4'h2:    b.alu = ALU_SUB;
      4'h3:    b.alu = ALU_AND;
      4'h4:    b.alu = ALU_NOR;
      4'h5:    b.alu = ALU_SLL;
      4'h6:    b.alu = ALU_SRL;
      4'h7:    b.alu = ALU_SRA;
      4'hA:    b.alu = ALU_LHB;
      default: b.alu = ALU_ADD;
    endcase
    b.src1sel = !((op >= 4'h5) && (op <= 4'hB));
    b.shamt   = (op >= 4'h5 && op <= 4'h7) ? i[3:0] : 4'd0;
    if (op == 4'h8 || op == 4'h9)      b.imm = {{12{i[3]}}, i[3:0]};
    else if (op == 4'hA || op == 4'hB) b.imm = {{8{i[7]}}, i[7:0]};
    b.branch  = (op == 4'hC);
    b.br_cond = i[11:9];
    b.hlt     = (op == 4'hF);
    return b;
  endfunction

  function automatic bun_t sample();
    bun_t b;
    b = '{pc: out_pc, p0: p0_addr, p1: p1_addr, dst: dst_addr, re0: re0, re1: re1,
          we: we, we_zr: we_zr, mem_rd: mem_rd, mem_wr: mem_wr, alu: alu_op,
          src1sel: src1sel, shamt: shamt, imm: imm, branch: branch,
          br_cond: br_cond, hlt: hlt};
    return b;
  endfunction

  function automatic bun_t pop_exp();
    if (sb.size() == 0) return '1;
    return sb.pop_front();
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [15:0] i, input logic [15:0] pc);
    in_valid = 1'b1;
    in_instr = i;
    in_pc    = pc;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; flush = 1'b0; out_ready = 1'b1;
    cyc(); cyc();
    if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready_low got=%0b want=0", in_ready); end
    checks++;
    rst_n = 1'b1;
    #1;
    if (out_valid !== 1'b0 || stall !== 1'b0 || halted !== 1'b0) begin
      errors++; $display("FAIL reset_flags got=%0b%0b%0b want=000", out_valid, stall, halted);
    end
    checks++;
    g = sample();
    if (g !== '0) begin errors++; $display("FAIL reset_bundle got=%h want=0", g); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%0b want=1", in_ready); end
    checks++;
  endtask

  task automatic test_add();
    present(16'h0312, 16'h0010);
    if (in_ready !== 1'b1) begin errors++; $display("FAIL add_in_ready got=%0b want=1", in_ready); end
    checks++;
    sb.push_back(ref_decode(16'h0312, 16'h0010));
    cyc();
    in_valid = 1'b0;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL add_valid got=%0b want=1", out_valid); end
    checks++;
    if (p0_addr !== 4'd1 || p1_addr !== 4'd2 || dst_addr !== 4'd3 || we !== 1'b1 || alu_op !== ALU_ADD) begin
      errors++; $display("FAIL add_fields got=%h/%h/%h/%b/%0d want=1/2/3/1/%0d",
                         p0_addr, p1_addr, dst_addr, we, alu_op, ALU_ADD);
    end
    checks++;
    e = pop_exp(); g = sample();
    if (g !== e) begin errors++; $display("FAIL add_bundle got=%h want=%h", g, e); end
    checks++;
    cyc();
    if (out_valid !== 1'b0) begin errors++; $display("FAIL add_drain got=%0b want=0", out_valid); end
    checks++;
  endtask

  task automatic test_back_to_back();
    logic [15:0] prog [3];
    prog[0] = 16'h8412; prog[1] = 16'h0512; prog[2] = 16'h2623;
    for (int k = 0; k < 3; k++) begin
      present(prog[k], 16'h0020 + 16'(k));
      if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready[%0d] got=%0b want=1", k, in_ready); end
      checks++;
      sb.push_back(ref_decode(prog[k], 16'h0020 + 16'(k)));
      cyc();
      e = pop_exp(); g = sample();
      if (out_valid !== 1'b1 || stall !== 1'b0 || g !== e) begin
        errors++; $display("FAIL b2b_bundle[%0d] got=%0b %h want=1 %h", k, out_valid, g, e);
      end
      checks++;
    end
    in_valid = 1'b0;
    cyc();
  endtask

  task automatic test_load_use();
    present(16'h8410, 16'h0030);
    sb.push_back(ref_decode(16'h8410, 16'h0030));
    cyc();
    e = pop_exp(); g = sample();
    if (out_valid !== 1'b1 || g !== e) begin errors++; $display("FAIL lu_lw got=%0b %h want=1 %h", out_valid, g, e); end
    checks++;
    present(16'h0541, 16'h0031);
    for (int k = 0; k < 2; k++) begin
      if (in_ready !== 1'b0) begin errors++; $display("FAIL lu_in_ready[%0d] got=%0b want=0", k, in_ready); end
      checks++;
      cyc();
      if (out_valid !== 1'b0 || stall !== 1'b1) begin
        errors++; $display("FAIL lu_bubble[%0d] got=%0b%0b want=01", k, out_valid, stall);
      end
      checks++;
    end
    if (in_ready !== 1'b1) begin errors++; $display("FAIL lu_release got=%0b want=1", in_ready); end
    checks++;
    sb.push_back(ref_decode(16'h0541, 16'h0031));
    cyc();
    in_valid = 1'b0;
    e = pop_exp(); g = sample();
    if (out_valid !== 1'b1 || stall !== 1'b0 || g !== e) begin
      errors++; $display("FAIL lu_issue got=%0b%0b %h want=10 %h", out_valid, stall, g, e);
    end
    checks++;
    cyc();
  endtask

  task automatic test_backpressure();
    bun_t held;
    present(16'h3712, 16'h0040);
    sb.push_back(ref_decode(16'h3712, 16'h0040));
    cyc();
    held = pop_exp();
    out_ready = 1'b0;
    present(16'h4834, 16'h0041);
    for (int k = 0; k < 3; k++) begin
      if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d] got=%0b want=0", k, in_ready); end
      checks++;
      g = sample();
      if (out_valid !== 1'b1 || g !== held) begin
        errors++; $display("FAIL bp_hold[%0d] got=%0b %h want=1 %h", k, out_valid, g, held);
      end
      checks++;
      cyc();
    end
    out_ready = 1'b1;
    #1;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_resume got=%0b want=1", in_ready); end
    checks++;
    sb.push_back(ref_decode(16'h4834, 16'h0041));
    cyc();
    in_valid = 1'b0;
    e = pop_exp(); g = sample();
    if (out_valid !== 1'b1 || g !== e) begin errors++; $display("FAIL bp_next got=%0b %h want=1 %h", out_valid, g, e); end
    checks++;
    cyc();
  endtask

  task automatic test_flush();
    present(16'h8910, 16'h0050);
    sb.push_back(ref_decode(16'h8910, 16'h0050));
    cyc();
    e = pop_exp(); g = sample();
    if (g !== e) begin errors++; $display("FAIL fl_lw got=%h want=%h", g, e); end
    checks++;
    flush = 1'b1;
    present(16'h0A91, 16'h0051);
    if (in_ready !== 1'b0) begin errors++; $display("FAIL fl_in_ready got=%0b want=0", in_ready); end
    checks++;
    cyc();
    flush = 1'b0;
    if (out_valid !== 1'b0 || stall !== 1'b0 || dut.ld_cnt !== 2'd0) begin
      errors++; $display("FAIL fl_kill got=%0b%0b cnt=%0d want=00 cnt=0", out_valid, stall, dut.ld_cnt);
    end
    checks++;
    #1;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL fl_represent got=%0b want=1", in_ready); end
    checks++;
    sb.push_back(ref_decode(16'h0A91, 16'h0051));
    cyc();
    in_valid = 1'b0;
    e = pop_exp(); g = sample();
    if (out_valid !== 1'b1 || stall !== 1'b0 || g !== e) begin
      errors++; $display("FAIL fl_accept got=%0b%0b %h want=10 %h", out_valid, stall, g, e);
    end
    checks++;
    cyc();
  endtask

  task automatic test_sw();
    present(16'h967F, 16'h0060);
    sb.push_back(ref_decode(16'h967F, 16'h0060));
    cyc();
    in_valid = 1'b0;
    if (mem_wr !== 1'b1 || p1_addr !== 4'd6 || p0_addr !== 4'd7 || imm !== 16'hFFFF || we !== 1'b0) begin
      errors++; $display("FAIL sw_fields got=%b/%h/%h/%h/%b want=1/6/7/ffff/0", mem_wr, p1_addr, p0_addr, imm, we);
    end
    checks++;
    e = pop_exp(); g = sample();
    if (g !== e) begin errors++; $display("FAIL sw_bundle got=%h want=%h", g, e); end
    checks++;
    cyc();
  endtask

  task automatic test_decode_mix();
    logic [3:0]  ops [10];
    logic [15:0] ins;
    ops = '{4'h1, 4'h2, 4'h4, 4'h5, 4'h6, 4'h7, 4'hA, 4'hB, 4'hC, 4'hD};
    for (int k = 0; k < 20; k++) begin
      ins = {ops[k % 10], 12'($urandom)};
      present(ins, 16'h0100 + 16'(k));
      sb.push_back(ref_decode(ins, 16'h0100 + 16'(k)));
      cyc();
      e = pop_exp(); g = sample();
      if (out_valid !== 1'b1 || g !== e) begin
        errors++; $display("FAIL mix[%0d] instr=%h got=%0b %h want=1 %h", k, ins, out_valid, g, e);
      end
      checks++;
    end
    in_valid = 1'b0;
    cyc();
  endtask

  task automatic test_halt();
    present(16'hF000, 16'h0070);
    sb.push_back(ref_decode(16'hF000, 16'h0070));
    cyc();
    e = pop_exp(); g = sample();
    if (hlt !== 1'b1 || halted !== 1'b1 || g !== e) begin
      errors++; $display("FAIL halt_bundle got=%0b%0b %h want=11 %h", hlt, halted, g, e);
    end
    checks++;
    present(16'h0312, 16'h0071);
    for (int k = 0; k < 4; k++) begin
      if (in_ready !== 1'b0 || halted !== 1'b1) begin
        errors++; $display("FAIL halt_sticky[%0d] got=%0b%0b want=01", k, in_ready, halted);
      end
      checks++;
      cyc();
    end
    #2;
    rst_n = 1'b0;
    #1;
    g = sample();
    if (g !== '0 || out_valid !== 1'b0 || halted !== 1'b0 || stall !== 1'b0 || in_ready !== 1'b0) begin
      errors++; $display("FAIL async_reset got=%h %0b%0b%0b%0b want=0 0000", g, out_valid, halted, stall, in_ready);
    end
    checks++;
    in_valid = 1'b0;
    cyc();
    rst_n = 1'b1;
    #1;
    if (in_ready !== 1'b1 || halted !== 1'b0) begin
      errors++; $display("FAIL post_reset got=%0b%0b want=10", in_ready, halted);
    end
    checks++;
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_load_use();
    test_backpressure();
    test_flush();
    test_sw();
    test_decode_mix();
    test_halt();
    if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_left got=%0d want=0", sb.size()); end
    checks++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
